timer_peripheral: RTL and testbench

- Memory-mapped peripheral block for the single-cycle MIPS CPU. It answers the MemRead/MemWrite accesses the control unit issues to the 0x4000_00xx I/O space.
- It is the source of the IRQ line that the control unit consumes, in the form of a reloading 32-bit timer with a sticky interrupt-status bit.
- It also provides a free-running systick counter, an LED output register and a switch input register.
- It sits beside the data memory. The CPU muxes ReadData by address (Addr[30] = 1 selects this block).

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_core.sv | 55 +++++
 rtl/timer_peripheral.sv | 86 ++++++++
 tb/tb_timer_peripheral.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped timer peripheral.
package timer_pkg;

  // Register offsets from the peripheral base address
  localparam logic [31:0] ADDR_TH      = 32'h0000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h0000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h0000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h0000_000C;
  localparam logic [31:0] ADDR_SW      = 32'h0000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h0000_0014;

  // TCON bit positions
  localparam int TCON_TEN = 0;
  localparam int TCON_TIE = 1;
  localparam int TCON_TIF = 2;

  // Reset values
  localparam logic [31:0] TH_RST      = 32'h0000_0000;
  localparam logic [31:0] TL_RST      = 32'h0000_0000;
  localparam logic [2:0]  TCON_RST    = 3'b000;
  localparam logic [31:0] SYSTICK_RST = 32'h0000_0000;

endpackage

// File: rtl/timer_core.sv
// Reloading 32-bit up-counter with sticky interrupt flag and level IRQ.
module timer_core
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic        tcon_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;

  // Next-state: CPU writes to TL beat the reload, but a hardware TIF set beats a CPU clear
  always_comb begin
    ovf    = tcon_q[TCON_TEN] && (tl_q == 32'hFFFF_FFFF);
    th_d   = th_we_i ? wdata_i : th_q;
    tl_d   = tl_q;
    if (tl_we_i)
      tl_d = wdata_i;
    else if (tcon_q[TCON_TEN])
      tl_d = ovf ? th_q : tl_q + 32'd1;
    tcon_d = tcon_we_i ? wdata_i[2:0] : tcon_q;
    if (ovf && tcon_q[TCON_TIE])
      tcon_d[TCON_TIF] = 1'b1;
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= TH_RST;
      tl_q   <= TL_RST;
      tcon_q <= TCON_RST;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  // Driven purely from flops, so no path from the bus into the IRQ line
  assign irq_o  = tcon_q[TCON_TIF] & tcon_q[TCON_TIE];

endmodule

// File: rtl/timer_peripheral.sv
// I/O-space peripheral: address decode, read mux, LED, switch sync, systick.
module timer_peripheral
  import timer_pkg::*;
#(
  parameter logic [31:0] TIMER_BASE = 32'h4000_0000,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [SW_W-1:0]  switch,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] led,
  output logic             IRQ
);

  localparam logic [31:0] A_TH      = TIMER_BASE + ADDR_TH;
  localparam logic [31:0] A_TL      = TIMER_BASE + ADDR_TL;
  localparam logic [31:0] A_TCON    = TIMER_BASE + ADDR_TCON;
  localparam logic [31:0] A_LED     = TIMER_BASE + ADDR_LED;
  localparam logic [31:0] A_SW      = TIMER_BASE + ADDR_SW;
  localparam logic [31:0] A_SYSTICK = TIMER_BASE + ADDR_SYSTICK;

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [31:0]      systick_q;
  logic [31:0]      th, tl;
  logic [2:0]       tcon;
  logic             th_we, tl_we, tcon_we;

  assign th_we   = MemWrite && (Addr == A_TH);
  assign tl_we   = MemWrite && (Addr == A_TL);
  assign tcon_we = MemWrite && (Addr == A_TCON);
  assign led_d   = (MemWrite && (Addr == A_LED)) ? WriteData[LED_W-1:0] : led_q;

  timer_core u_core (
    .clk       (clk),
    .reset     (reset),
    .th_we_i   (th_we),
    .tl_we_i   (tl_we),
    .tcon_we_i (tcon_we),
    .wdata_i   (WriteData),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (IRQ)
  );

  // LED register, switch synchroniser and free-running systick
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      systick_q <= SYSTICK_RST;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      systick_q <= systick_q + 32'd1;
    end
  end

  // Zero-latency read mux; returns pre-write values when a store happens in the same cycle
  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      case (Addr)
        A_TH:      ReadData = th;
        A_TL:      ReadData = tl;
        A_TCON:    ReadData = {29'h0, tcon};
        A_LED:     ReadData = 32'(led_q);
        A_SW:      ReadData = 32'(sw_sync_q);
        A_SYSTICK: ReadData = systick_q;
        default:   ReadData = 32'h0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral with hand-computed expectations.
module tb_timer_peripheral;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE + 32'h00;
  localparam logic [31:0] A_TL  = BASE + 32'h04;
  localparam logic [31:0] A_TC  = BASE + 32'h08;
  localparam logic [31:0] A_LED = BASE + 32'h0C;
  localparam logic [31:0] A_SW  = BASE + 32'h10;
  localparam logic [31:0] A_ST  = BASE + 32'h14;
  localparam logic [31:0] A_BAD = BASE + 32'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr, WriteData, ReadData;
  logic        MemRead, MemWrite, IRQ;
  logic [7:0]  switch, led;

  int errors = 0;
  int checks = 0;
  logic [31:0] st0;

  always #10 clk = ~clk;

  timer_peripheral #(.TIMER_BASE(BASE), .LED_W(8), .SW_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .switch    (switch),
    .ReadData  (ReadData),
    .led       (led),
    .IRQ       (IRQ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Addr = a; MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    Addr = a; MemRead = 1'b1;
    #1;
    v = ReadData;
    MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Addr = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    switch = 8'h5A;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    rd_chk("rst_th", A_TH, 32'h0);
    rd_chk("rst_tl", A_TL, 32'h0);
    rd_chk("rst_tcon", A_TC, 32'h0);
    rd_chk("rst_led", A_LED, 32'h0);
    rd_chk("rst_sw", A_SW, 32'h0);
    rd_chk("rst_systick", A_ST, 32'h0);
    rd_chk("rst_unmapped", A_BAD, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    tick();
    rd_chk("sw_sync1", A_SW, 32'h0);
    tick();
    rd_chk("sw_sync2", A_SW, 32'h5A);
    Addr = A_SW; MemRead = 1'b0; #1;
    chk("noread_zero", ReadData, 32'h0);

    // 2: count and overflow with reload
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_TC, 32'h3);
    rd_chk("tl_start", A_TL, 32'hFFFF_FFFC);
    tick(); rd_chk("tl_fffd", A_TL, 32'hFFFF_FFFD);
    tick(); rd_chk("tl_fffe", A_TL, 32'hFFFF_FFFE);
    tick(); rd_chk("tl_ffff", A_TL, 32'hFFFF_FFFF);
    chk("irq_pre_ovf", {31'h0, IRQ}, 32'h0);
    tick(); rd_chk("tl_reload", A_TL, 32'hFFFF_FFFC);
    chk("irq_ovf", {31'h0, IRQ}, 32'h1);
    rd_chk("tcon_tif", A_TC, 32'h7);

    // 3: clear TIF; clear coinciding with overflow loses to the hardware set
    wr(A_TC, 32'h3);
    chk("irq_cleared", {31'h0, IRQ}, 32'h0);
    rd_chk("tcon_cleared", A_TC, 32'h3);
    rd_chk("tl_after_clr", A_TL, 32'hFFFF_FFFD);
    tick(); tick();
    rd_chk("tl_ffff_b", A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    chk("irq_hw_wins", {31'h0, IRQ}, 32'h1);
    rd_chk("tcon_hw_wins", A_TC, 32'h7);
    rd_chk("tl_reload_b", A_TL, 32'hFFFF_FFFC);

    // 4: TIE off overflow, then freeze
    wr(A_TC, 32'h1);
    chk("irq_tie0", {31'h0, IRQ}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("irq_never", {31'h0, IRQ}, 32'h0);
    end
    rd_chk("tl_reload_tie0", A_TL, 32'hFFFF_FFFC);
    rd_chk("tcon_tie0", A_TC, 32'h1);
    wr(A_TC, 32'h0);
    rd_chk("tl_stop", A_TL, 32'hFFFF_FFFD);
    for (int i = 0; i < 10; i++) tick();
    rd_chk("tl_frozen", A_TL, 32'hFFFF_FFFD);

    // Collisions: TL write vs overflow, TH write vs reload
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    rd_chk("tl_hold_en", A_TL, 32'hFFFF_FFFE);
    tick();
    wr(A_TL, 32'h0000_0100);
    rd_chk("tl_cpu_wins", A_TL, 32'h0000_0100);
    rd_chk("tcon_tl_coll", A_TC, 32'h7);
    chk("irq_tl_coll", {31'h0, IRQ}, 32'h1);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h0000_0055);
    rd_chk("tl_old_th", A_TL, 32'hFFFF_FFFC);
    rd_chk("th_new", A_TH, 32'h0000_0055);
    wr(A_TC, 32'h0);
    chk("irq_off", {31'h0, IRQ}, 32'h0);

    // 5: LED, read-only and unmapped writes, systick
    wr(A_LED, 32'h0000_01A5);
    chk("led_pin", {24'h0, led}, 32'hA5);
    rd_chk("led_read", A_LED, 32'hA5);
    rd(A_ST, st0);
    wr(A_ST, 32'h0);
    rd_chk("systick_ro", A_ST, st0 + 32'd1);
    wr(A_BAD, 32'h0000_0033);
    rd_chk("unmapped_rd", A_BAD, 32'h0);
    chk("led_unmapped", {24'h0, led}, 32'hA5);
    rd_chk("th_unmapped", A_TH, 32'h0000_0055);
    rd(A_ST, st0);
    for (int i = 0; i < 5; i++) tick();
    rd_chk("systick_plus5", A_ST, st0 + 32'd5);
    Addr = A_LED; WriteData = 32'h3C; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    chk("rw_pre_data", ReadData, 32'hA5);
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("rw_written", {24'h0, led}, 32'h3C);

    // 6: reset mid-count with IRQ pending
    wr(A_TL, 32'h0000_1234);
    wr(A_TC, 32'h6);
    chk("irq_pre_rst", {31'h0, IRQ}, 32'h1);
    rd_chk("tl_pre_rst", A_TL, 32'h0000_1234);
    reset = 1'b1;
    tick();
    rd_chk("tl_post_rst", A_TL, 32'h0);
    rd_chk("tcon_post_rst", A_TC, 32'h0);
    rd_chk("th_post_rst", A_TH, 32'h0);
    chk("irq_post_rst", {31'h0, IRQ}, 32'h0);
    chk("led_post_rst", {24'h0, led}, 32'h0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
